clk_divider: RTL and testbench



---
 rtl/clk_divider.sv | 42 ++++
 tb/tb_clk_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - programmable integer clock divider, 50% duty, period 2*N clk_in cycles
module clk_divider #(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] div_half_N,
    output logic                     clk_out
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] cnt_nxt;
    logic                     clk_out_nxt;

    // A >= compare lets a run-time shrink of N end the current phase at once instead of wrapping.
    always_comb begin
        cnt_nxt     = cnt;
        clk_out_nxt = clk_out;
        if (div_half_N == '0) begin
            cnt_nxt     = '0;
            clk_out_nxt = 1'b0;
        end else if (cnt >= (div_half_N - ONE)) begin
            cnt_nxt     = '0;
            clk_out_nxt = ~clk_out;
        end else begin
            cnt_nxt     = cnt + ONE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            clk_out <= clk_out_nxt;
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - self-checking bench for clk_divider
module tb_clk_divider;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] div_half_N = '0;
    logic         clk_out;

    clk_divider #(.COUNTER_WIDTH(W)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_half_N (div_half_N),
        .clk_out    (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int   n_checks = 0;
    int   n_pass = 0;
    logic m_level = 1'b0;
    int   m_elapsed = 0;

    typedef struct {
        logic [W-1:0] n;
        int           edges;
        logic         exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: clk_out=%0b expected %0b at %0t", name, act, exp, $time);
    endtask

    // Reference: count edges spent in the current half-period; flip level once N have elapsed.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (div_half_N == 0) begin
            m_elapsed = 0;
            m_level   = 1'b0;
        end else begin
            m_elapsed++;
            if (m_elapsed >= int'(div_half_N)) begin
                m_elapsed = 0;
                m_level   = ~m_level;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst       = 1'b1;
        m_level   = 1'b0;
        m_elapsed = 0;
        #1;
        check("reset", clk_out, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'd9,   8,   1'b0};
        vecs[1]  = '{8'd9,   9,   1'b1};
        vecs[2]  = '{8'd9,   17,  1'b1};
        vecs[3]  = '{8'd9,   18,  1'b0};
        vecs[4]  = '{8'd1,   1,   1'b1};
        vecs[5]  = '{8'd1,   2,   1'b0};
        vecs[6]  = '{8'd0,   20,  1'b0};
        vecs[7]  = '{8'd5,   5,   1'b1};
        vecs[8]  = '{8'd255, 254, 1'b0};
        vecs[9]  = '{8'd255, 255, 1'b1};
        vecs[10] = '{8'd255, 509, 1'b1};
        vecs[11] = '{8'd255, 510, 1'b0};

        rst = 1'b1;
        #12;
        check("por", clk_out, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_reset();
            div_half_N = vecs[i].n;
            repeat (vecs[i].edges) tick();
            check($sformatf("vec%0d", i), clk_out, vecs[i].exp);
        end

        // basic divide by 18
        do_reset();
        div_half_N = 8'd9;
        for (int e = 1; e <= 22; e++) begin
            tick();
            check("basic", clk_out, (e >= 9 && e <= 17));
        end

        // divide by 2
        do_reset();
        div_half_N = 8'd1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("div2", clk_out, (e % 2) == 1);
        end

        // park on zero, then restart with N=3
        do_reset();
        div_half_N = 8'd0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("park", clk_out, 1'b0);
        end
        div_half_N = 8'd3;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("unpark", clk_out, e == 3);
        end

        // shrink N mid-phase
        do_reset();
        div_half_N = 8'd10;
        repeat (7) tick();
        check("shrink_pre", clk_out, 1'b0);
        div_half_N = 8'd4;
        tick();
        check("shrink_toggle", clk_out, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("shrink_after", clk_out, (e < 4) || (e == 8));
        end

        // async reset while high
        do_reset();
        div_half_N = 8'd5;
        repeat (6) tick();
        check("async_pre", clk_out, 1'b1);
        @(negedge clk_in);
        rst = 1'b1;
        m_level   = 1'b0;
        m_elapsed = 0;
        #1;
        check("async_drop", clk_out, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("async_restart", clk_out, e == 5);
        end

        // maximum ratio, both phases exactly 255 cycles
        do_reset();
        div_half_N = 8'd255;
        for (int e = 1; e <= 520; e++) begin
            tick();
            check("max", clk_out, (e >= 255 && e < 510));
        end

        // randomized run-time N changes and resets against the reference
        do_reset();
        div_half_N = 8'd4;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                div_half_N = W'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk_in);
                rst = 1'b1;
                m_level   = 1'b0;
                m_elapsed = 0;
                #1;
                check("rand_rst", clk_out, 1'b0);
                @(negedge clk_in);
                rst = 1'b0;
            end else begin
                tick();
                check("rand", clk_out, m_level);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
